// File: rtl/inv_pipeline_if.sv
// Handshake bundle for inv_pipeline: input word/mode/mask channel and output word channel.
// master = source/sink side, slave = the inverter pipeline itself.
interface inv_pipeline_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] inp;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] mask;
  logic             mask_load;
  logic [WIDTH-1:0] op;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output inp, in_valid, mode, mask, mask_load, out_ready,
    input  in_ready, op, out_valid
  );

  modport slave (
    input  inp, in_valid, mode, mask, mask_load, out_ready,
    output in_ready, op, out_valid
  );
endinterface

// File: rtl/inv_pipeline.sv
// Registered, mode-selectable inverter bank behind a DEPTH-stage elastic valid/ready pipeline.
// Define INV_PIPELINE_BLINK_EN to build the blink generator; otherwise mode 11 equals mode 10.
module inv_pipeline #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int PERIOD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  inv_pipeline_if.slave  bus
);

  logic [WIDTH-1:0] r_mask;
  logic             w_phase;
  logic [WIDTH-1:0] w_xform;

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_din  [DEPTH];

  function automatic logic [WIDTH-1:0] xform(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] msk,
    input logic             ph
  );
    case (m)
      2'b00:   xform = d;
      2'b01:   xform = ~d;
      2'b10:   xform = d ^ msk;
      default: xform = d ^ (msk & {WIDTH{ph}});
    endcase
  endfunction

`ifdef INV_PIPELINE_BLINK_EN
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_W'(PERIOD - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_phase = r_phase;
`else
  // Phase pinned high makes mode 11 select the full mask, identical to mode 10.
  assign w_phase = 1'b1;
`endif

  // Words accepted in a mask_load cycle still see the old mask (NBA ordering).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '1;
    end else if (bus.mask_load) begin
      r_mask <= bus.mask;
    end
  end

  assign w_xform = xform(bus.mode, bus.inp, r_mask, w_phase);

  // Stage k may move when any stage from k to the tail has a bubble, or the sink pops.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_ready[k] = bus.out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!r_vld[j]) w_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_vin    = '0;
    w_vin[0] = bus.in_valid;
    w_din[0] = w_xform;
    for (int k = 1; k < DEPTH; k++) begin
      w_vin[k] = r_vld[k-1];
      w_din[k] = r_data[k-1];
    end
  end

  // Stage registers s0..s(DEPTH-1); data only loads under a valid word so bubbles never touch op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ready[k]) begin
          r_vld[k] <= w_vin[k];
          if (w_vin[k]) r_data[k] <= w_din[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.op        = r_data[DEPTH-1];
  assign bus.out_valid = r_vld[DEPTH-1];

endmodule

// File: tb/tb_inv_pipeline.sv
// Scoreboard bench for inv_pipeline: directed scenarios plus randomized traffic against a behavioural model.
module tb_inv_pipeline;
  localparam int W = 8;
  localparam int D = 2;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_pipeline_if #(.WIDTH(W)) bus ();

  inv_pipeline #(.WIDTH(W), .DEPTH(D), .PERIOD(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_mask;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

`ifdef INV_PIPELINE_BLINK_EN
  int ncyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end
`endif

  // Reference: what the specification says the word becomes at acceptance.
  function automatic logic [W-1:0] model(input logic [1:0] md, input logic [W-1:0] d,
                                         input logic [W-1:0] msk);
    logic [W-1:0] blink_msk;
`ifdef INV_PIPELINE_BLINK_EN
    blink_msk = (((ncyc / P) % 2) == 1) ? msk : '0;
`else
    blink_msk = msk;
`endif
    case (md)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return d ^ msk;
      default: return d ^ blink_msk;
    endcase
  endfunction

  // Stimulus side of the scoreboard: record every accepted word's expected result.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mask = '1;
    end else begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.mode, bus.inp, m_mask));
      if (bus.mask_load) m_mask = bus.mask;
    end
  end

  // Monitor: compare every transfer out, and check op/out_valid are held under a stall.
  logic         h_pend;
  logic [W-1:0] h_op;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pend = 1'b0;
      h_op   = '0;
    end else begin
      if (h_pend) begin
        check("hold_vld", 32'(bus.out_valid), 32'd1);
        check("hold_op", 32'(bus.op), 32'(h_op));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(bus.op), 32'hDEAD_BEEF);
        end else begin
          check("sb_op", 32'(bus.op), 32'(exp_q.pop_front()));
        end
      end
      h_pend = bus.out_valid && !bus.out_ready;
      h_op   = bus.op;
    end
  end

  logic [W-1:0] d_a [4];
  logic [W-1:0] e_a [4];

  // Push n words back to back with the sink always ready; checks latency and ordering.
  task automatic burst(input int n, input logic [1:0] md, input logic ld0, input logic [W-1:0] mk);
    for (int j = 0; j < n + D; j++) begin
      bus.in_valid  = (j < n);
      bus.inp       = (j < n) ? d_a[j] : '0;
      bus.mode      = md;
      bus.mask_load = ld0 && (j == 0);
      bus.mask      = mk;
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (j < n) check("burst_in_ready", 32'(bus.in_ready), 32'd1);
      if (j < D) check("burst_idle", 32'(bus.out_valid), 32'd0);
      else begin
        check("burst_vld", 32'(bus.out_valid), 32'd1);
        check("burst_op", 32'(bus.op), 32'(e_a[j-D]));
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.mask_load = 1'b0;
    @(negedge clk);
    check("burst_after", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int w;
    logic b [16];
    int trans;

    rst_n = 1'b0;
    bus.inp = '0; bus.in_valid = 1'b0; bus.mode = 2'b00;
    bus.mask = '0; bus.mask_load = 1'b0; bus.out_ready = 1'b0;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_op", 32'(bus.op), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    #9 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Pass-through of a single word
    d_a[0] = 8'hA5; e_a[0] = 8'hA5;
    burst(1, 2'b00, 1'b0, 8'h00);

    // Inverted stream
    d_a[0] = 8'h00; d_a[1] = 8'hFF; d_a[2] = 8'h3C;
    e_a[0] = 8'hFF; e_a[1] = 8'h00; e_a[2] = 8'hC3;
    burst(3, 2'b01, 1'b0, 8'h00);

    // Mask load in the same cycle as a push: old mask applies first
    d_a[0] = 8'hFF; d_a[1] = 8'hFF;
    e_a[0] = 8'h00; e_a[1] = 8'hF0;
    burst(2, 2'b10, 1'b1, 8'h0F);

    // Backpressure: only DEPTH words fit
    acc = 0;
    bus.out_ready = 1'b0;
    bus.mode = 2'b00;
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.inp = 8'(8'h11 * (j + 1));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", 32'(acc), 32'(D));
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < D + 2; j++) begin @(posedge clk); #1; end
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Blink: mask 0x01, mode 11, zero words every cycle
    bus.mask = 8'h01; bus.mask_load = 1'b1;
    @(posedge clk); #1;
    bus.mask_load = 1'b0;
    bus.mode = 2'b11;
    bus.inp = 8'h00;
    bus.in_valid = 1'b1;
    for (int j = 0; j < 12 + D; j++) begin
      if (j == 12) bus.in_valid = 1'b0;
      @(negedge clk);
      if (j >= D) begin
        b[j-D] = bus.op[0];
        check("blink_hi", 32'(bus.op[W-1:1]), 32'd0);
`ifndef INV_PIPELINE_BLINK_EN
        check("blink_const", 32'(bus.op), 32'h01);
`endif
      end
      @(posedge clk); #1;
    end
`ifdef INV_PIPELINE_BLINK_EN
    trans = 0;
    for (int j = 1; j < 12; j++) if (b[j] != b[j-1]) trans++;
    for (int j = P; j < 12; j++) check("blink_alt", 32'(b[j]), 32'(~b[j-P]));
    check("blink_runs", 32'(trans <= (11 / P) + 1), 32'd1);
`endif

    // Async reset with two words in flight
    bus.out_ready = 1'b0;
    bus.mode = 2'b00;
    bus.in_valid = 1'b1;
    bus.inp = 8'h5A;
    @(posedge clk); #1;
    bus.inp = 8'h6B;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_vld", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_op", 32'(bus.op), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    d_a[0] = 8'hFF; e_a[0] = 8'h00;
    burst(1, 2'b10, 1'b0, 8'h00);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.inp       = W'($urandom);
      bus.mode      = 2'($urandom_range(0, 3));
      bus.mask_load = ($urandom_range(0, 7) == 0);
      bus.mask      = W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.mask_load = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
